pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline (PC, IF_ID, ID_EX, EX_MEM, MEM_WB). It collects stall requests from each stage, branch redirects from ID and exceptions from MEM. Each cycle it drives per-register hold (stall) and bubble (flush) controls plus the PC redirect. It sits beside the datapath and feeds the stall/flush inputs of every pipeline register.

---
 rtl/pipeline_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-register hold/bubble controls plus PC redirect.
// Optional perf counters guarded by PIPE_CTRL_PERF_EN; outputs are combinational, state is registered.
module pipeline_ctrl #(
  parameter int ADDR_WIDTH       = 32,
  parameter int EXC_FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_stall_i,
  input  logic                  id_stall_i,
  input  logic                  ex_stall_i,
  input  logic                  mem_stall_i,
  input  logic                  br_taken_i,
  input  logic [ADDR_WIDTH-1:0] br_target_i,
  input  logic                  exc_i,
  input  logic [ADDR_WIDTH-1:0] exc_target_i,
  output logic [4:0]            stall_o,
  output logic [4:0]            flush_o,
  output logic                  redirect_o,
  output logic [ADDR_WIDTH-1:0] redirect_target_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           flush_events_o
`endif
);

  typedef enum logic [1:0] {S_RUN, S_PEND, S_FLUSH} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(EXC_FLUSH_CYCLES);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_tgt;
  logic                  r_pend_exc;

  state_t                w_nstate;
  logic [3:0]            w_ncnt;
  logic [ADDR_WIDTH-1:0] w_ntgt;
  logic                  w_npexc;
  logic [4:0]            w_stall;
  logic [4:0]            w_flush;
  logic                  w_redir;
  logic [ADDR_WIDTH-1:0] w_tgt_sel;
  logic                  w_down_stall;
  logic                  w_pc_load;

  assign w_down_stall = id_stall_i | ex_stall_i | mem_stall_i;

  always_comb begin
    w_stall   = 5'b00000;
    w_flush   = 5'b00000;
    w_redir   = 1'b0;
    w_tgt_sel = '0;
    w_nstate  = r_state;
    w_ncnt    = r_cnt;
    w_ntgt    = r_tgt;
    w_npexc   = r_pend_exc;
    if (exc_i) begin
      w_flush   = 5'b11110;
      w_redir   = 1'b1;
      w_tgt_sel = exc_target_i;
      if (if_stall_i) begin
        w_nstate = S_PEND;
        w_ntgt   = exc_target_i;
        w_npexc  = 1'b1;
      end else begin
        w_nstate = S_FLUSH;
        w_ncnt   = FLUSH_INIT;
        w_npexc  = 1'b0;
      end
    end else begin
      // Highest stalled stage wins: it holds everything upstream and bubbles itself.
      if (mem_stall_i) begin
        w_stall = 5'b01111;
        w_flush = 5'b10000;
      end else if (ex_stall_i) begin
        w_stall = 5'b00111;
        w_flush = 5'b01000;
      end else if (id_stall_i) begin
        w_stall = 5'b00011;
        w_flush = 5'b00100;
      end else if (if_stall_i) begin
        w_stall = 5'b00001;
        w_flush = 5'b00010;
      end
      case (r_state)
        S_RUN: begin
          // A branch under a downstream stall is dropped; ID presents it again.
          if (br_taken_i && !w_down_stall) begin
            if (!if_stall_i) begin
              w_redir    = 1'b1;
              w_tgt_sel  = br_target_i;
              w_flush[1] = 1'b1;
            end else begin
              w_nstate = S_PEND;
              w_ntgt   = br_target_i;
              w_npexc  = 1'b0;
            end
          end
        end
        S_PEND: begin
          w_redir   = 1'b1;
          w_tgt_sel = r_tgt;
          if (!w_stall[1]) w_flush[1] = 1'b1;
          if (!w_stall[0]) begin
            w_nstate = r_pend_exc ? S_FLUSH : S_RUN;
            w_ncnt   = r_pend_exc ? FLUSH_INIT : 4'd0;
            w_npexc  = 1'b0;
          end
        end
        S_FLUSH: begin
          w_flush[1] = 1'b1;
          if (!w_stall[1]) begin
            if (r_cnt <= 4'd1) begin
              w_nstate = S_RUN;
              w_ncnt   = 4'd0;
            end else begin
              w_ncnt = r_cnt - 4'd1;
            end
          end
        end
        default: w_nstate = S_RUN;
      endcase
    end
  end

  // The exception cycle itself does not load the PC when fetch is stalled; PEND repeats it.
  assign w_pc_load = w_redir && !w_stall[0] && !(exc_i && if_stall_i);

  assign stall_o           = rst ? 5'b00000 : w_stall;
  assign flush_o           = rst ? 5'b00000 : w_flush;
  assign redirect_o        = rst ? 1'b0 : w_redir;
  assign redirect_target_o = rst ? '0 : w_tgt_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_cnt      <= 4'd0;
      r_tgt      <= '0;
      r_pend_exc <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_cnt      <= w_ncnt;
      r_tgt      <= w_ntgt;
      r_pend_exc <= w_npexc;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
      r_flush_events <= 32'd0;
    end else begin
      if (w_stall[0]) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_pc_load)  r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign stall_cycles_o = r_stall_cycles;
  assign flush_events_o = r_flush_events;
`else
  logic w_unused;
  assign w_unused = w_pc_load;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: drives inputs on the falling edge and checks outputs 1ns later.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall_i, id_stall_i, ex_stall_i, mem_stall_i;
  logic        br_taken_i, exc_i;
  logic [31:0] br_target_i, exc_target_i;
  logic [4:0]  stall_o, flush_o;
  logic        redirect_o;
  logic [31:0] redirect_target_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_o, flush_events_o;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.ADDR_WIDTH(32), .EXC_FLUSH_CYCLES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_stall_i        (if_stall_i),
    .id_stall_i        (id_stall_i),
    .ex_stall_i        (ex_stall_i),
    .mem_stall_i       (mem_stall_i),
    .br_taken_i        (br_taken_i),
    .br_target_i       (br_target_i),
    .exc_i             (exc_i),
    .exc_target_i      (exc_target_i),
    .stall_o           (stall_o),
    .flush_o           (flush_o),
    .redirect_o        (redirect_o),
    .redirect_target_o (redirect_target_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles_o    (stall_cycles_o),
    .flush_events_o    (flush_events_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, settle 1ns before checking.
  task automatic drive(input logic ifs, input logic ids, input logic exs, input logic mems,
                       input logic br, input logic [31:0] brt,
                       input logic exc, input logic [31:0] exct);
    @(negedge clk);
    if_stall_i   = ifs;
    id_stall_i   = ids;
    ex_stall_i   = exs;
    mem_stall_i  = mems;
    br_taken_i   = br;
    br_target_i  = brt;
    exc_i        = exc;
    exc_target_i = exct;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] st, input logic [4:0] fl,
                            input logic rd, input logic [31:0] tg);
    check({tag, ".stall"},  64'(stall_o),           64'(st));
    check({tag, ".flush"},  64'(flush_o),           64'(fl));
    check({tag, ".redir"},  64'(redirect_o),        64'(rd));
    check({tag, ".target"}, 64'(redirect_target_o), 64'(tg));
  endtask

  initial begin
    rst = 1'b1;
    if_stall_i = 0; id_stall_i = 0; ex_stall_i = 0; mem_stall_i = 0;
    br_taken_i = 0; br_target_i = 0; exc_i = 0; exc_target_i = 0;
    #1;
    expect_out("reset", 5'b00000, 5'b00000, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_out("idle", 5'b00000, 5'b00000, 1'b0, 32'h0);

    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      expect_out($sformatf("id_stall%0d", i), 5'b00011, 5'b00100, 1'b0, 32'h0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("id_release", 5'b00000, 5'b00000, 1'b0, 32'h0);

    drive(1, 0, 0, 1, 0, 0, 0, 0);
    expect_out("mem_if", 5'b01111, 5'b10000, 1'b0, 32'h0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    expect_out("ex_stall", 5'b00111, 5'b01000, 1'b0, 32'h0);

    drive(0, 0, 0, 0, 1, 32'h0000_1000, 0, 0);
    expect_out("br", 5'b00000, 5'b00010, 1'b1, 32'h0000_1000);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("br_after", 5'b00000, 5'b00000, 1'b0, 32'h0);

    drive(0, 1, 0, 0, 1, 32'h0000_4000, 0, 0);
    expect_out("br_under_id", 5'b00011, 5'b00100, 1'b0, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("br_dropped", 5'b00000, 5'b00000, 1'b0, 32'h0);

    drive(1, 0, 0, 0, 1, 32'h0000_2000, 0, 0);
    expect_out("brp0", 5'b00001, 5'b00010, 1'b0, 32'h0);
    for (int i = 1; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      expect_out($sformatf("brp%0d", i), 5'b00001, 5'b00010, 1'b1, 32'h0000_2000);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("brp3.stall",  64'(stall_o),           64'h0);
    check("brp3.redir",  64'(redirect_o),        64'h1);
    check("brp3.target", 64'(redirect_target_o), 64'h2000);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("brp_run", 5'b00000, 5'b00000, 1'b0, 32'h0);

    drive(0, 0, 1, 0, 1, 32'h0000_5000, 1, 32'h8000_0180);
    expect_out("exc", 5'b00000, 5'b11110, 1'b1, 32'h8000_0180);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      expect_out($sformatf("exc_fl%0d", i), 5'b00000, 5'b00010, 1'b0, 32'h0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("exc_done", 5'b00000, 5'b00000, 1'b0, 32'h0);

    drive(1, 0, 0, 0, 0, 0, 1, 32'h0000_0200);
    expect_out("excp", 5'b00000, 5'b11110, 1'b1, 32'h0000_0200);
    drive(1, 0, 0, 0, 1, 32'h0000_6000, 0, 0);
    expect_out("excp_pend", 5'b00001, 5'b00010, 1'b1, 32'h0000_0200);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("excp_load", 5'b00000, 5'b00010, 1'b1, 32'h0000_0200);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      expect_out($sformatf("excp_fl%0d", i), 5'b00000, 5'b00010, 1'b0, 32'h0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("excp_done", 5'b00000, 5'b00000, 1'b0, 32'h0);

    drive(1, 0, 0, 0, 1, 32'h0000_3000, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("rstp.redir", 64'(redirect_o), 64'h1);
    rst = 1'b1;
    #1;
    expect_out("rst_async", 5'b00000, 5'b00000, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    if_stall_i = 0;
    br_taken_i = 0;
    #1;
    expect_out("rst_run", 5'b00000, 5'b00000, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
